// File: rtl/dcpu16_pkg.sv
// Shared definitions for the DCPU-16 memory controller slice: FSM states,
// port selects, data width and the round-robin pick helper.
package dcpu16_pkg;

  localparam int MC_DW = 16;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_WAIT = 2'd1,
    MC_ACK  = 2'd2
  } mc_state_t;

  localparam logic MC_PORT_F = 1'b0;
  localparam logic MC_PORT_G = 1'b1;

  // On a conflict the port that was not served last wins; otherwise the lone requester.
  function automatic logic rr_pick(input logic f_req, input logic g_req, input logic last);
    logic pick;
    if (f_req && g_req) begin
      pick = (last == MC_PORT_G) ? MC_PORT_F : MC_PORT_G;
    end else if (f_req) begin
      pick = MC_PORT_F;
    end else begin
      pick = MC_PORT_G;
    end
    return pick;
  endfunction

endpackage

// File: rtl/dcpu16_mctl_if.sv
// The CPU's two simplified-Wishbone memory buses (F: fetch/write-back, G: operand read).
interface dcpu16_mctl_if;
  import dcpu16_pkg::*;

  logic [MC_DW-1:0] f_adr;
  logic             f_stb;
  logic             f_wre;
  logic [MC_DW-1:0] f_dto;
  logic [MC_DW-1:0] f_dti;
  logic             f_ack;

  logic [MC_DW-1:0] g_adr;
  logic             g_stb;
  logic             g_wre;
  logic [MC_DW-1:0] g_dto;
  logic [MC_DW-1:0] g_dti;
  logic             g_ack;

  modport master (
    output f_adr, f_stb, f_wre, f_dto,
    input  f_dti, f_ack,
    output g_adr, g_stb, g_wre, g_dto,
    input  g_dti, g_ack
  );

  modport slave (
    input  f_adr, f_stb, f_wre, f_dto,
    output f_dti, f_ack,
    input  g_adr, g_stb, g_wre, g_dto,
    output g_dti, g_ack
  );

endinterface

// File: rtl/dcpu16_sram.sv
// Single-port synchronous RAM, 2^AW x 16, registered read-first output.
module dcpu16_sram
  import dcpu16_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic             clk,
  input  logic [AW-1:0]    adr,
  input  logic             wre,
  input  logic [MC_DW-1:0] dti,
  output logic [MC_DW-1:0] dto
);

  logic [MC_DW-1:0] mem_r [2**AW];

  // Write at the edge; the output register captures the old contents (read-first).
  always_ff @(posedge clk) begin
    if (wre) begin
      mem_r[adr] <= dti;
    end
    dto <= mem_r[adr];
  end

endmodule

// File: rtl/dcpu16_mctl.sv
// Memory responder arbitrating F-BUS and G-BUS onto one single-port RAM,
// returning one-cycle acks after WAIT optional wait cycles.
module dcpu16_mctl
  import dcpu16_pkg::*;
#(
  parameter int AW   = 10,
  parameter int WAIT = 0
) (
  input  logic           clk,
  input  logic           rst,
  dcpu16_mctl_if.slave   bus
);

  if (WAIT < 0 || WAIT > 3) begin : g_wait_check
    $error("dcpu16_mctl: WAIT must be in 0..3");
  end

  localparam logic [1:0] WAIT_CNT = 2'((WAIT > 0) ? (WAIT - 1) : 0);

  mc_state_t        state_r;
  logic [1:0]       cnt_r;
  logic             last_r;
  logic             port_r;
  logic             wre_r;
  logic [AW-1:0]    adr_r;
  logic             ack_f_r;
  logic             ack_g_r;
  logic [MC_DW-1:0] f_dti_r;
  logic [MC_DW-1:0] g_dti_r;

  logic             req_s;
  logic             gnt_s;
  logic             go_s;
  logic [MC_DW-1:0] gnt_adr_s;
  logic             gnt_wre_s;
  logic [MC_DW-1:0] ram_dti_s;
  logic [AW-1:0]    ram_adr_s;
  logic             ram_wre_s;
  logic [MC_DW-1:0] ram_dto_s;

  // Grant selection and RAM port drive; outside the grant edge the RAM keeps
  // re-reading the latched address so its output stays valid through WAIT.
  always_comb begin
    req_s = bus.f_stb | bus.g_stb;
    gnt_s = rr_pick(bus.f_stb, bus.g_stb, last_r);
    go_s  = (state_r == MC_IDLE) && req_s && !rst;
    if (gnt_s == MC_PORT_F) begin
      gnt_adr_s = bus.f_adr;
      gnt_wre_s = bus.f_wre;
      ram_dti_s = bus.f_dto;
    end else begin
      gnt_adr_s = bus.g_adr;
      gnt_wre_s = bus.g_wre;
      ram_dti_s = bus.g_dto;
    end
    if (go_s) begin
      ram_adr_s = gnt_adr_s[AW-1:0];
      ram_wre_s = gnt_wre_s;
    end else begin
      ram_adr_s = adr_r;
      ram_wre_s = 1'b0;
    end
  end

  dcpu16_sram #(.AW(AW)) u_sram (
    .clk (clk),
    .adr (ram_adr_s),
    .wre (ram_wre_s),
    .dti (ram_dti_s),
    .dto (ram_dto_s)
  );

  // Transaction FSM: grant in IDLE, count down in WAIT, one-cycle ack in ACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= MC_IDLE;
      cnt_r   <= 2'd0;
      last_r  <= MC_PORT_G;
      port_r  <= MC_PORT_F;
      wre_r   <= 1'b0;
      adr_r   <= '0;
      ack_f_r <= 1'b0;
      ack_g_r <= 1'b0;
    end else begin
      ack_f_r <= 1'b0;
      ack_g_r <= 1'b0;
      case (state_r)
        MC_IDLE: begin
          if (req_s) begin
            port_r <= gnt_s;
            last_r <= gnt_s;
            adr_r  <= gnt_adr_s[AW-1:0];
            wre_r  <= gnt_wre_s;
            if (WAIT == 0) begin
              state_r <= MC_ACK;
              ack_f_r <= (gnt_s == MC_PORT_F);
              ack_g_r <= (gnt_s == MC_PORT_G);
            end else begin
              state_r <= MC_WAIT;
              cnt_r   <= WAIT_CNT;
            end
          end
        end
        MC_WAIT: begin
          if (cnt_r == 2'd0) begin
            state_r <= MC_ACK;
            ack_f_r <= (port_r == MC_PORT_F);
            ack_g_r <= (port_r == MC_PORT_G);
          end else begin
            cnt_r <= cnt_r - 2'd1;
          end
        end
        MC_ACK: begin
          state_r <= MC_IDLE;
        end
        default: begin
          state_r <= MC_IDLE;
        end
      endcase
    end
  end

  // Read-data holding registers: each is refreshed only when its own read completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_dti_r <= 16'h0000;
      g_dti_r <= 16'h0000;
    end else if (ack_f_r && !wre_r) begin
      f_dti_r <= ram_dto_s;
    end else if (ack_g_r && !wre_r) begin
      g_dti_r <= ram_dto_s;
    end
  end

  // Acks are gated by the live strobe so an abandoned request never stalls the CPU.
  assign bus.f_ack = ack_f_r & bus.f_stb;
  assign bus.g_ack = ack_g_r & bus.g_stb;
  assign bus.f_dti = (ack_f_r && !wre_r) ? ram_dto_s : f_dti_r;
  assign bus.g_dti = (ack_g_r && !wre_r) ? ram_dto_s : g_dti_r;

endmodule

// File: tb/tb_dcpu16_mctl.sv
// Directed bench for dcpu16_mctl: three instances (WAIT=0, 3, 2) share one
// stimulus driver; sel picks which instance sees the strobes and is observed.
module tb_dcpu16_mctl;
  import dcpu16_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sel = 2'd0;
  logic [15:0] drv_f_adr = 16'h0000, drv_f_dto = 16'h0000;
  logic [15:0] drv_g_adr = 16'h0000, drv_g_dto = 16'h0000;
  logic        drv_f_stb = 1'b0, drv_f_wre = 1'b0, drv_g_stb = 1'b0, drv_g_wre = 1'b0;
  logic [15:0] obs_f_dti, obs_g_dti;
  logic        obs_f_ack, obs_g_ack;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  dcpu16_mctl_if b0 ();
  dcpu16_mctl_if b3 ();
  dcpu16_mctl_if b2 ();

  dcpu16_mctl #(.AW(10), .WAIT(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  dcpu16_mctl #(.AW(10), .WAIT(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
  dcpu16_mctl #(.AW(10), .WAIT(2)) u2 (.clk(clk), .rst(rst), .bus(b2));

  assign b0.f_adr = drv_f_adr; assign b0.f_wre = drv_f_wre; assign b0.f_dto = drv_f_dto;
  assign b0.g_adr = drv_g_adr; assign b0.g_wre = drv_g_wre; assign b0.g_dto = drv_g_dto;
  assign b0.f_stb = drv_f_stb & (sel == 2'd0); assign b0.g_stb = drv_g_stb & (sel == 2'd0);
  assign b3.f_adr = drv_f_adr; assign b3.f_wre = drv_f_wre; assign b3.f_dto = drv_f_dto;
  assign b3.g_adr = drv_g_adr; assign b3.g_wre = drv_g_wre; assign b3.g_dto = drv_g_dto;
  assign b3.f_stb = drv_f_stb & (sel == 2'd1); assign b3.g_stb = drv_g_stb & (sel == 2'd1);
  assign b2.f_adr = drv_f_adr; assign b2.f_wre = drv_f_wre; assign b2.f_dto = drv_f_dto;
  assign b2.g_adr = drv_g_adr; assign b2.g_wre = drv_g_wre; assign b2.g_dto = drv_g_dto;
  assign b2.f_stb = drv_f_stb & (sel == 2'd2); assign b2.g_stb = drv_g_stb & (sel == 2'd2);

  always_comb begin
    case (sel)
      2'd1:    begin obs_f_ack = b3.f_ack; obs_f_dti = b3.f_dti; obs_g_ack = b3.g_ack; obs_g_dti = b3.g_dti; end
      2'd2:    begin obs_f_ack = b2.f_ack; obs_f_dti = b2.f_dti; obs_g_ack = b2.g_ack; obs_g_dti = b2.g_dti; end
      default: begin obs_f_ack = b0.f_ack; obs_f_dti = b0.f_dti; obs_g_ack = b0.g_ack; obs_g_dti = b0.g_dti; end
    endcase
  end

  // Bus transaction on F; call at posedge+1, returns at posedge+1 with stb low.
  // lat = cycles from issue to ack (-1 if no ack within the budget).
  task automatic f_xact(input logic wre, input logic [15:0] adr, input logic [15:0] dto,
                        output logic [15:0] rdata, output int lat);
    drv_f_wre = wre; drv_f_adr = adr; drv_f_dto = dto; drv_f_stb = 1'b1;
    lat = -1; rdata = 16'h0000;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (obs_f_ack === 1'b1) begin lat = c; rdata = obs_f_dti; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    drv_f_stb = 1'b0;
  endtask

  task automatic g_xact(input logic wre, input logic [15:0] adr, input logic [15:0] dto,
                        output logic [15:0] rdata, output int lat);
    drv_g_wre = wre; drv_g_adr = adr; drv_g_dto = dto; drv_g_stb = 1'b1;
    lat = -1; rdata = 16'h0000;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (obs_g_ack === 1'b1) begin lat = c; rdata = obs_g_dti; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    drv_g_stb = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = 2'(k);
      #1;
      n_cmp++; if (obs_f_ack !== 1'b0 || obs_g_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack[%0d]: f_ack=%b g_ack=%b, want 0 0", k, obs_f_ack, obs_g_ack); end
      n_cmp++; if (obs_f_dti !== 16'h0000 || obs_g_dti !== 16'h0000) begin n_bad++; $display("FAIL reset_dti[%0d]: f_dti=%h g_dti=%h, want 0000 0000", k, obs_f_dti, obs_g_dti); end
    end
    sel = 2'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    logic [15:0] rd; int lat;
    sel = 2'd0;
    f_xact(1'b1, 16'h0005, 16'hBEEF, rd, lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL wr_latency: got %0d, want 1", lat); end
    drv_f_wre = 1'b0; drv_f_adr = 16'h0005; drv_f_stb = 1'b1;
    @(negedge clk);
    n_cmp++; if (obs_f_ack !== 1'b0) begin n_bad++; $display("FAIL rd_c0_ack: f_ack=%b, want 0", obs_f_ack); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (obs_f_ack !== 1'b1 || obs_g_ack !== 1'b0) begin n_bad++; $display("FAIL rd_c1_ack: f_ack=%b g_ack=%b, want 1 0", obs_f_ack, obs_g_ack); end
    n_cmp++; if (obs_f_dti !== 16'hBEEF) begin n_bad++; $display("FAIL rd_c1_dti: f_dti=%h, want beef", obs_f_dti); end
    @(posedge clk); #1;
    drv_f_stb = 1'b0;
    @(negedge clk);
    n_cmp++; if (obs_f_ack !== 1'b0 || obs_f_dti !== 16'hBEEF) begin n_bad++; $display("FAIL rd_c2_hold: f_ack=%b f_dti=%h, want 0 beef", obs_f_ack, obs_f_dti); end
    @(posedge clk); #1;
  endtask

  task automatic test_arbitration();
    logic [15:0] rd; int lat;
    f_xact(1'b1, 16'h0010, 16'h1111, rd, lat);
    f_xact(1'b1, 16'h0020, 16'h2222, rd, lat);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drv_f_wre = 1'b0; drv_f_adr = 16'h0010; drv_g_wre = 1'b0; drv_g_adr = 16'h0020;
    drv_f_stb = 1'b1; drv_g_stb = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (obs_f_ack !== 1'b1 || obs_g_ack !== 1'b0 || obs_f_dti !== 16'h1111) begin n_bad++; $display("FAIL arb1_f_first: f_ack=%b g_ack=%b f_dti=%h, want 1 0 1111", obs_f_ack, obs_g_ack, obs_f_dti); end
    @(posedge clk); #1;
    drv_f_stb = 1'b0;
    @(negedge clk);
    n_cmp++; if (obs_f_ack !== 1'b0 || obs_g_ack !== 1'b0) begin n_bad++; $display("FAIL arb1_gap: f_ack=%b g_ack=%b, want 0 0", obs_f_ack, obs_g_ack); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (obs_g_ack !== 1'b1 || obs_f_ack !== 1'b0 || obs_g_dti !== 16'h2222) begin n_bad++; $display("FAIL arb1_g_second: g_ack=%b f_ack=%b g_dti=%h, want 1 0 2222", obs_g_ack, obs_f_ack, obs_g_dti); end
    @(posedge clk); #1;
    drv_g_stb = 1'b0;
    // A lone F read leaves last-grant at F, so the next conflict goes to G.
    f_xact(1'b0, 16'h0010, 16'h0000, rd, lat);
    n_cmp++; if (rd !== 16'h1111) begin n_bad++; $display("FAIL arb_lone_f: rdata=%h, want 1111", rd); end
    drv_f_adr = 16'h0020; drv_g_adr = 16'h0010; drv_f_stb = 1'b1; drv_g_stb = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (obs_g_ack !== 1'b1 || obs_f_ack !== 1'b0 || obs_g_dti !== 16'h1111) begin n_bad++; $display("FAIL arb2_g_first: g_ack=%b f_ack=%b g_dti=%h, want 1 0 1111", obs_g_ack, obs_f_ack, obs_g_dti); end
    n_cmp++; if (obs_f_dti !== 16'h1111) begin n_bad++; $display("FAIL arb2_f_undisturbed: f_dti=%h, want 1111", obs_f_dti); end
    @(posedge clk); #1;
    drv_g_stb = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (obs_f_ack !== 1'b1 || obs_f_dti !== 16'h2222) begin n_bad++; $display("FAIL arb2_f_second: f_ack=%b f_dti=%h, want 1 2222", obs_f_ack, obs_f_dti); end
    @(posedge clk); #1;
    drv_f_stb = 1'b0;
  endtask

  task automatic test_write_read();
    logic [15:0] rd; int lat;
    drv_f_wre = 1'b1; drv_f_adr = 16'h0042; drv_f_dto = 16'h1234; drv_f_stb = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (obs_f_ack !== 1'b1 || obs_f_dti !== 16'h2222) begin n_bad++; $display("FAIL wr_ack_dti: f_ack=%b f_dti=%h, want 1 2222", obs_f_ack, obs_f_dti); end
    @(posedge clk); #1;
    drv_f_stb = 1'b0; drv_f_wre = 1'b0;
    g_xact(1'b0, 16'h0042, 16'h0000, rd, lat);
    n_cmp++; if (rd !== 16'h1234 || lat !== 1) begin n_bad++; $display("FAIL wr_then_g_rd: rdata=%h lat=%0d, want 1234 1", rd, lat); end
    n_cmp++; if (obs_f_dti !== 16'h2222) begin n_bad++; $display("FAIL wr_f_dti_kept: f_dti=%h, want 2222", obs_f_dti); end
  endtask

  task automatic test_alias_and_drop();
    logic [15:0] rd; int lat;
    f_xact(1'b1, 16'h0403, 16'hAAAA, rd, lat);
    g_xact(1'b0, 16'h0003, 16'h0000, rd, lat);
    n_cmp++; if (rd !== 16'hAAAA) begin n_bad++; $display("FAIL alias_rd: rdata=%h, want aaaa", rd); end
    // Strobe dropped before ack: ack suppressed but the write still lands.
    drv_f_wre = 1'b1; drv_f_adr = 16'h0077; drv_f_dto = 16'h7070; drv_f_stb = 1'b1;
    @(posedge clk); #1;
    drv_f_stb = 1'b0;
    @(negedge clk);
    n_cmp++; if (obs_f_ack !== 1'b0) begin n_bad++; $display("FAIL drop_ack: f_ack=%b, want 0", obs_f_ack); end
    @(posedge clk); #1;
    drv_f_wre = 1'b0;
    g_xact(1'b0, 16'h0077, 16'h0000, rd, lat);
    n_cmp++; if (rd !== 16'h7070) begin n_bad++; $display("FAIL drop_write_kept: rdata=%h, want 7070", rd); end
  endtask

  task automatic test_wait3();
    logic [15:0] rd; int lat; logic exp_ack;
    sel = 2'd1;
    f_xact(1'b1, 16'h0007, 16'h7777, rd, lat);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL w3_wr_latency: got %0d, want 4", lat); end
    drv_g_wre = 1'b0; drv_g_adr = 16'h0007; drv_g_stb = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      exp_ack = (c == 4 || c == 9);
      n_cmp++; if (obs_g_ack !== exp_ack) begin n_bad++; $display("FAIL w3_ack_c%0d: g_ack=%b, want %b", c, obs_g_ack, exp_ack); end
      if (c == 4) begin
        n_cmp++; if (obs_g_dti !== 16'h7777) begin n_bad++; $display("FAIL w3_dti: g_dti=%h, want 7777", obs_g_dti); end
      end
      @(posedge clk); #1;
    end
    drv_g_stb = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [15:0] rd; int lat; logic seen;
    sel = 2'd2;
    f_xact(1'b1, 16'h0056, 16'h2222, rd, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL w2_wr_latency: got %0d, want 3", lat); end
    drv_f_wre = 1'b1; drv_f_adr = 16'h0055; drv_f_dto = 16'h5A5A; drv_f_stb = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (obs_f_ack !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
      if (c == 0) rst = 1'b1;
      if (c == 1) begin rst = 1'b0; drv_f_stb = 1'b0; end
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_ack: ack seen=%b, want 0", seen); end
    // Request whose grant edge coincides with reset must not be performed.
    rst = 1'b1; drv_f_adr = 16'h0056; drv_f_dto = 16'h1111; drv_f_stb = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; drv_f_stb = 1'b0; drv_f_wre = 1'b0;
    @(posedge clk); #1;
    f_xact(1'b0, 16'h0055, 16'h0000, rd, lat);
    n_cmp++; if (rd !== 16'h5A5A || lat !== 3) begin n_bad++; $display("FAIL abort_write_kept: rdata=%h lat=%0d, want 5a5a 3", rd, lat); end
    f_xact(1'b0, 16'h0056, 16'h0000, rd, lat);
    n_cmp++; if (rd !== 16'h2222) begin n_bad++; $display("FAIL rst_grant_dropped: rdata=%h, want 2222", rd); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_arbitration();
    test_write_read();
    test_alias_and_drop();
    test_wait3();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
